// File: rtl/max_pool_stage.sv
// 2x2 stride-2 max-pooling over raster-ordered feature maps, one pixel per cycle.
// Optional POOL_RELU_EN: clamp negative pooled results to zero before registering.
module max_pool_stage #(
  parameter int unsigned BitSize     = 32,
  parameter int unsigned ImageWidth  = 4,
  parameter int unsigned NumberOfK   = 4,
  localparam int unsigned KernelWidth = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [BitSize-1:0]     in_data,
  input  logic                   in_valid,
  output logic [BitSize-1:0]     out_data,
  output logic                   out_valid,
  output logic [KernelWidth-1:0] out_kernel,
  output logic                   pooling_done,
  output logic                   all_done
);

  localparam int unsigned Half     = ImageWidth / 2;
  localparam int unsigned CntWidth = (ImageWidth > 2) ? $clog2(ImageWidth) : 1;
  localparam int unsigned IdxWidth = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [CntWidth-1:0]    LastPos = CntWidth'(ImageWidth - 1);
  localparam logic [KernelWidth-1:0] LastMap = KernelWidth'(NumberOfK - 1);

  if (((ImageWidth % 2) != 0) || (ImageWidth < 2)) begin : gen_bad_width
    $error("max_pool_stage: ImageWidth must be even and >= 2");
  end
  if (NumberOfK < 1) begin : gen_bad_k
    $error("max_pool_stage: NumberOfK must be >= 1");
  end

  typedef enum logic [1:0] {StEven, StOdd, StDone} state_e;

  state_e                 state_q;
  logic [CntWidth-1:0]    col_q;
  logic [CntWidth-1:0]    row_q;
  logic [KernelWidth-1:0] map_q;
  logic [BitSize-1:0]     hold_q;
  logic [BitSize-1:0]     linebuf_q [Half];

  function automatic logic [BitSize-1:0] smax(input logic [BitSize-1:0] a,
                                               input logic [BitSize-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  logic                accept;
  logic                end_row;
  logic                last_row;
  logic [IdxWidth-1:0] pair_idx;
  logic [BitSize-1:0]  pair_max;
  logic [BitSize-1:0]  pool_max;
  logic [BitSize-1:0]  result;

  // Pixels arriving while the done pulse is issued are dropped, keeping alignment intact.
  assign accept   = in_valid && (state_q != StDone);
  assign end_row  = (col_q == LastPos);
  assign last_row = (row_q == LastPos);
  assign pair_idx = IdxWidth'(col_q >> 1);
  assign pair_max = smax(hold_q, in_data);
  assign pool_max = smax(pair_max, linebuf_q[pair_idx]);

`ifdef POOL_RELU_EN
  assign result = pool_max[BitSize-1] ? '0 : pool_max;
`else
  assign result = pool_max;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= StEven;
      col_q        <= '0;
      row_q        <= '0;
      map_q        <= '0;
      hold_q       <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_kernel   <= '0;
      pooling_done <= 1'b0;
      all_done     <= 1'b0;
      for (int i = 0; i < int'(Half); i++) begin
        linebuf_q[i] <= '0;
      end
    end else begin
      out_valid    <= 1'b0;
      pooling_done <= 1'b0;
      all_done     <= 1'b0;
      unique case (state_q)
        StEven, StOdd: begin
          if (accept) begin
            if (!col_q[0]) begin
              hold_q <= in_data;
            end else if (state_q == StEven) begin
              linebuf_q[pair_idx] <= pair_max;
            end else begin
              out_data   <= result;
              out_valid  <= 1'b1;
              out_kernel <= map_q;
            end
            if (end_row) begin
              col_q <= '0;
              row_q <= last_row ? '0 : row_q + CntWidth'(1);
              if (state_q == StEven) begin
                state_q <= StOdd;
              end else begin
                state_q <= last_row ? StDone : StEven;
              end
            end else begin
              col_q <= col_q + CntWidth'(1);
            end
          end
        end
        StDone: begin
          pooling_done <= 1'b1;
          all_done     <= (map_q == LastMap);
          map_q        <= (map_q == LastMap) ? '0 : map_q + KernelWidth'(1);
          state_q      <= StEven;
        end
        default: state_q <= StEven;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_stage.sv
// Scoreboard bench for max_pool_stage: a window-based reference model predicts pooled
// pixels and done pulses; a negedge monitor pops and compares whatever the DUT emits.
module tb_max_pool_stage;

  localparam int unsigned BitSize    = 32;
  localparam int unsigned ImageWidth = 4;
  localparam int unsigned NumberOfK  = 4;
  localparam int unsigned KW         = 2;

  logic               clk = 1'b0;
  logic               res_n = 1'b0;
  logic [BitSize-1:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic [BitSize-1:0] out_data;
  logic               out_valid;
  logic [KW-1:0]      out_kernel;
  logic               pooling_done;
  logic               all_done;

  max_pool_stage #(
    .BitSize   (BitSize),
    .ImageWidth(ImageWidth),
    .NumberOfK (NumberOfK)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_kernel  (out_kernel),
    .pooling_done(pooling_done),
    .all_done    (all_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int data;
    int kern;
    int when;
  } pix_exp_t;

  typedef struct {
    int when;
    int all;
  } done_exp_t;

  pix_exp_t  pix_q[$];
  done_exp_t done_q[$];

  // Reference model: whole map stored as a 2D array, pooled window computed directly.
  int  pix [ImageWidth][ImageWidth];
  int  mr, mc, mmap;
  bit  drop_next;

  task automatic model_reset();
    mr = 0; mc = 0; mmap = 0; drop_next = 0;
    pix_q.delete();
    done_q.delete();
  endtask

  task automatic model_step(input bit v, input int d);
    bit acc;
    int m;
    acc = v && !drop_next;
    drop_next = 0;
    if (acc) begin
      pix[mr][mc] = d;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        m = pix[mr-1][mc-1];
        if (pix[mr-1][mc] > m) m = pix[mr-1][mc];
        if (pix[mr][mc-1] > m) m = pix[mr][mc-1];
        if (pix[mr][mc]   > m) m = pix[mr][mc];
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        pix_q.push_back('{data: m, kern: mmap, when: cyc + 1});
      end
      mc++;
      if (mc == ImageWidth) begin
        mc = 0;
        mr++;
        if (mr == ImageWidth) begin
          mr = 0;
          done_q.push_back('{when: cyc + 2, all: (mmap == NumberOfK - 1) ? 1 : 0});
          mmap = (mmap + 1) % NumberOfK;
          drop_next = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input int d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    model_step(v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  // kind: 0 ramp from base, 1 random full range, 2 random small range (ties likely)
  task automatic send_map(input int kind, input int base, input int gap_pct);
    int v;
    for (int i = 0; i < ImageWidth * ImageWidth; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, $urandom);
      case (kind)
        0:       v = base + i;
        1:       v = $urandom;
        default: v = int'($urandom_range(6)) - 3;
      endcase
      drive(1'b1, v);
    end
  endtask

  always @(negedge clk) begin
    if (res_n) begin
      if (out_valid) begin
        if (pix_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          pix_pop();
        end
      end
      if (pooling_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_pooling_done", 1, 0);
        end else begin
          done_pop();
        end
      end else if (all_done) begin
        check("all_done_without_pooling_done", 1, 0);
      end
    end
  end

  task automatic pix_pop();
    pix_exp_t e;
    e = pix_q.pop_front();
    check("out_data", longint'($signed(out_data)), e.data);
    check("out_kernel", out_kernel, e.kern);
    check("out_valid_cycle", cyc, e.when);
  endtask

  task automatic done_pop();
    done_exp_t e;
    e = done_q.pop_front();
    check("pooling_done_cycle", cyc, e.when);
    check("all_done", all_done, e.all);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_kernel"}, out_kernel, 0);
    check({tag, "_pooling_done"}, pooling_done, 0);
    check({tag, "_all_done"}, all_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #23;
    check_outputs_zero("reset");
    @(negedge clk);
    res_n = 1'b1;

    // Directed maps 0..3: ramp, negatives, ramp with toggling valid, random.
    send_map(0, 0, 0);
    idle(3);
    send_map(0, -16, 0);
    idle(2);
    for (int i = 0; i < ImageWidth * ImageWidth; i++) begin
      drive(1'b1, i);
      drive(1'b0, 99);
    end
    idle(2);
    send_map(1, 0, 0);
    idle(3);

    // Four maps with a single idle cycle between them.
    for (int k = 0; k < NumberOfK; k++) begin
      send_map(1, 0, 0);
      idle(1);
    end
    idle(2);

    // Pixel offered during the done cycle must be dropped.
    send_map(2, 0, 0);
    drive(1'b1, 32'h7fff_0000);
    send_map(0, 100, 0);
    idle(3);

    // Random maps with random stalls.
    for (int k = 0; k < 10; k++) begin
      send_map(k % 3, -8, 30);
      if ($urandom_range(1) == 1) idle($urandom_range(3));
    end
    idle(4);

    // Reset in the middle of a map, then a fresh map must start at map index 0.
    if (mmap != 0) begin
      while (mmap != 0) send_map(1, 0, 0);
      idle(3);
    end
    send_map(1, 0, 0);
    for (int i = 0; i < 9; i++) drive(1'b1, $urandom);
    drive(1'b0, 0);
    @(negedge clk);
    #1;
    res_n = 1'b0;
    #1;
    check_outputs_zero("midmap_reset");
    model_reset();
    @(negedge clk);
    res_n = 1'b1;
    send_map(0, 0, 0);
    idle(4);

    check("pending_outputs", pix_q.size(), 0);
    check("pending_done", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
